// File: rtl/ctrl_seq.sv
// Multicycle control sequencer: accepts one instruction per valid/ready handshake and strobes the datapath.
// Write strobe lands 1 cycle after accept for ALU/addi, 2 for sw, 3 for lw, 3+wait for mul/div; insn_ready is high only in IDLE.
module ctrl_seq #(
  parameter int OPW        = 5,
  parameter int FUNCW      = 5,
  parameter int ALUOPW     = 5,
  parameter int MD_TIMEOUT = 40,
  parameter int STATUSW    = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               insn_valid,
  output logic               insn_ready,
  input  logic [OPW-1:0]     opcode,
  input  logic [FUNCW-1:0]   alu_func,
  input  logic               alu_ovf,
  input  logic               md_ready,
  input  logic               md_exception,
  output logic               DMwe,
  output logic               Rwe,
  output logic [1:0]         Rwd,
  output logic               Rdst_status,
  output logic [ALUOPW-1:0]  ALUop,
  output logic               ALUinB,
  output logic               md_start_mult,
  output logic               md_start_div,
  output logic [STATUSW-1:0] rstatus_val,
  output logic               illegal
);

  localparam int CNTW = $clog2(MD_TIMEOUT + 1);

  localparam logic [OPW-1:0] OP_RTYPE = OPW'(5'b00000);
  localparam logic [OPW-1:0] OP_ADDI  = OPW'(5'b00101);
  localparam logic [OPW-1:0] OP_SW    = OPW'(5'b00111);
  localparam logic [OPW-1:0] OP_LW    = OPW'(5'b01000);

  localparam logic [FUNCW-1:0] FN_ADD = FUNCW'(5'b00000);
  localparam logic [FUNCW-1:0] FN_SUB = FUNCW'(5'b00001);
  localparam logic [FUNCW-1:0] FN_SRA = FUNCW'(5'b00101);
  localparam logic [FUNCW-1:0] FN_MUL = FUNCW'(5'b00110);
  localparam logic [FUNCW-1:0] FN_DIV = FUNCW'(5'b00111);

  localparam logic [1:0] WD_ALU  = 2'b00;
  localparam logic [1:0] WD_MEM  = 2'b01;
  localparam logic [1:0] WD_MD   = 2'b10;
  localparam logic [1:0] WD_STAT = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    EXEC   = 3'd1,
    MEM    = 3'd2,
    MDWAIT = 3'd3,
    WB     = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [OPW-1:0]    op_q, op_d;
  logic [FUNCW-1:0]  func_q, func_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic              md_exc_q, md_exc_d;

  // Decode of the latched instruction; never looks at the live opcode/func inputs.
  logic is_rtype, is_alu_r, is_addsub, is_sub, is_mul, is_div;
  logic is_addi, is_sw, is_lw;

  always_comb begin
    is_rtype  = (op_q == OP_RTYPE);
    is_alu_r  = is_rtype && (func_q <= FN_SRA);
    is_sub    = is_rtype && (func_q == FN_SUB);
    is_addsub = is_rtype && ((func_q == FN_ADD) || (func_q == FN_SUB));
    is_mul    = is_rtype && (func_q == FN_MUL);
    is_div    = is_rtype && (func_q == FN_DIV);
    is_addi   = (op_q == OP_ADDI);
    is_sw     = (op_q == OP_SW);
    is_lw     = (op_q == OP_LW);
  end

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    func_d        = func_q;
    cnt_d         = cnt_q;
    md_exc_d      = md_exc_q;
    insn_ready    = 1'b0;
    DMwe          = 1'b0;
    Rwe           = 1'b0;
    Rwd           = WD_ALU;
    Rdst_status   = 1'b0;
    ALUop         = '0;
    ALUinB        = 1'b0;
    md_start_mult = 1'b0;
    md_start_div  = 1'b0;
    rstatus_val   = '0;
    illegal       = 1'b0;

    // While reset is low every strobe stays quiet, even mid-instruction.
    if (reset) begin
      case (state_q)
        IDLE: begin
          insn_ready = 1'b1;
          if (insn_valid) begin
            op_d    = opcode;
            func_d  = alu_func;
            state_d = EXEC;
          end
        end

        EXEC: begin
          state_d = IDLE;
          if (is_alu_r) begin
            ALUop = ALUOPW'(func_q);
            Rwe   = 1'b1;
            if (is_addsub && alu_ovf) begin
              Rwd         = WD_STAT;
              Rdst_status = 1'b1;
              rstatus_val = is_sub ? STATUSW'(3) : STATUSW'(1);
            end
          end else if (is_mul || is_div) begin
            md_start_mult = is_mul;
            md_start_div  = is_div;
            cnt_d         = '0;
            state_d       = MDWAIT;
          end else if (is_addi) begin
            ALUinB = 1'b1;
            Rwe    = 1'b1;
            if (alu_ovf) begin
              Rwd         = WD_STAT;
              Rdst_status = 1'b1;
              rstatus_val = STATUSW'(2);
            end
          end else if (is_sw || is_lw) begin
            ALUinB  = 1'b1;
            state_d = MEM;
          end else begin
            illegal = 1'b1;
          end
        end

        MEM: begin
          // Address stays on the ALU for the synchronous memory read of lw.
          ALUinB = 1'b1;
          if (is_sw) begin
            DMwe    = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = WB;
          end
        end

        MDWAIT: begin
          cnt_d = cnt_q + CNTW'(1);
          if (md_ready) begin
            md_exc_d = md_exception;
            state_d  = WB;
          end else if (cnt_q == CNTW'(MD_TIMEOUT - 1)) begin
            md_exc_d = 1'b1;
            state_d  = WB;
          end
        end

        WB: begin
          Rwe     = 1'b1;
          state_d = IDLE;
          if (is_lw) begin
            Rwd = WD_MEM;
          end else if (md_exc_q) begin
            Rwd         = WD_STAT;
            Rdst_status = 1'b1;
            rstatus_val = is_div ? STATUSW'(5) : STATUSW'(4);
          end else begin
            Rwd = WD_MD;
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= IDLE;
      op_q     <= '0;
      func_q   <= '0;
      cnt_q    <= '0;
      md_exc_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      func_q   <= func_d;
      cnt_q    <= cnt_d;
      md_exc_q <= md_exc_d;
    end
  end

endmodule

// File: tb/tb_ctrl_seq.sv
// Directed bench for ctrl_seq: one instance at the default timeout, one with MD_TIMEOUT=8 for the timeout cases.
module tb_ctrl_seq;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        insn_valid = 1'b0;
  logic [4:0]  opcode = '0;
  logic [4:0]  alu_func = '0;
  logic        alu_ovf = 1'b0;
  logic        md_ready = 1'b0;
  logic        md_exception = 1'b0;

  logic        a_ready, a_dmwe, a_rwe, a_rdst, a_alub, a_sm, a_sd, a_ill;
  logic [1:0]  a_rwd;
  logic [4:0]  a_aluop;
  logic [31:0] a_stat;
  logic        b_ready, b_dmwe, b_rwe, b_rdst, b_alub, b_sm, b_sd, b_ill;
  logic [1:0]  b_rwd;
  logic [4:0]  b_aluop;
  logic [31:0] b_stat;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  ctrl_seq u_dut (
    .clock(clock), .reset(reset), .insn_valid(insn_valid), .insn_ready(a_ready),
    .opcode(opcode), .alu_func(alu_func), .alu_ovf(alu_ovf),
    .md_ready(md_ready), .md_exception(md_exception),
    .DMwe(a_dmwe), .Rwe(a_rwe), .Rwd(a_rwd), .Rdst_status(a_rdst),
    .ALUop(a_aluop), .ALUinB(a_alub), .md_start_mult(a_sm), .md_start_div(a_sd),
    .rstatus_val(a_stat), .illegal(a_ill)
  );

  ctrl_seq #(.MD_TIMEOUT(8)) u_dut8 (
    .clock(clock), .reset(reset), .insn_valid(insn_valid), .insn_ready(b_ready),
    .opcode(opcode), .alu_func(alu_func), .alu_ovf(alu_ovf),
    .md_ready(md_ready), .md_exception(md_exception),
    .DMwe(b_dmwe), .Rwe(b_rwe), .Rwd(b_rwd), .Rdst_status(b_rdst),
    .ALUop(b_aluop), .ALUinB(b_alub), .md_start_mult(b_sm), .md_start_div(b_sd),
    .rstatus_val(b_stat), .illegal(b_ill)
  );

  logic [14:0] a_vec, b_vec;
  assign a_vec = {a_ready, a_dmwe, a_rwe, a_rwd, a_rdst, a_aluop, a_alub, a_sm, a_sd, a_ill};
  assign b_vec = {b_ready, b_dmwe, b_rwe, b_rwd, b_rdst, b_aluop, b_alub, b_sm, b_sd, b_ill};

  // Field order: ready, DMwe, Rwe, Rwd, Rdst_status, ALUop, ALUinB, start_mult, start_div, illegal.
  function automatic logic [14:0] ov(input int rdy, input int dm, input int rwe, input int rwd,
                                     input int rdst, input int aluop, input int alub,
                                     input int sm, input int sd, input int ill);
    return {1'(rdy), 1'(dm), 1'(rwe), 2'(rwd), 1'(rdst), 5'(aluop), 1'(alub), 1'(sm), 1'(sd), 1'(ill)};
  endfunction

  localparam logic [14:0] V_IDLE = 15'h4000;
  localparam logic [14:0] V_ZERO = 15'h0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input bit sel8, input logic [14:0] ev, input int es);
    if (sel8) begin
      chk({tag, ".ctl8"}, 32'(b_vec), 32'(ev));
      chk({tag, ".stat8"}, b_stat, 32'(es));
    end else begin
      chk({tag, ".ctl"}, 32'(a_vec), 32'(ev));
      chk({tag, ".stat"}, a_stat, 32'(es));
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  // Present one instruction in IDLE, then scramble the inputs once it is accepted.
  task automatic issue(input logic [4:0] op, input logic [4:0] fn);
    insn_valid = 1'b1;
    opcode     = op;
    alu_func   = fn;
    tick();
    insn_valid = 1'b0;
    opcode     = 5'b11111;
    alu_func   = 5'b11111;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held two cycles, then released.
    tick(); #1 chk_out("rst0", 0, V_ZERO, 0); chk_out("rst0", 1, V_ZERO, 0);
    tick(); #1 chk_out("rst1", 0, V_ZERO, 0);
    reset = 1'b1;
    #1 chk_out("rel", 0, V_IDLE, 0); chk_out("rel", 1, V_IDLE, 0);

    // R-type ALU ops.
    issue(5'b00000, 5'b00000);
    #1 chk_out("add_ex", 0, ov(0,0,1,0,0,0,0,0,0,0), 0);
    tick(); #1 chk_out("add_idle", 0, V_IDLE, 0);
    issue(5'b00000, 5'b00010);
    #1 chk_out("and_ex", 0, ov(0,0,1,0,0,2,0,0,0,0), 0);
    tick();
    issue(5'b00000, 5'b00100);
    alu_ovf = 1'b1;
    #1 chk_out("sll_ovf_ignored", 0, ov(0,0,1,0,0,4,0,0,0,0), 0);
    tick(); alu_ovf = 1'b0;

    // addi with and without overflow, then sub with overflow.
    issue(5'b00101, 5'b00000);
    alu_ovf = 1'b1;
    #1 chk_out("addi_ovf", 0, ov(0,0,1,3,1,0,1,0,0,0), 2);
    tick(); alu_ovf = 1'b0;
    #1 chk_out("addi_ovf_idle", 0, V_IDLE, 0);
    issue(5'b00101, 5'b00000);
    #1 chk_out("addi", 0, ov(0,0,1,0,0,0,1,0,0,0), 0);
    tick();
    issue(5'b00000, 5'b00001);
    alu_ovf = 1'b1;
    #1 chk_out("sub_ovf", 0, ov(0,0,1,3,1,1,0,0,0,0), 3);
    tick(); alu_ovf = 1'b0;
    #1 chk_out("sub_ovf_idle", 0, V_IDLE, 0);

    // sw then lw with insn_valid held high throughout.
    insn_valid = 1'b1; opcode = 5'b00111; alu_func = 5'b00000;
    tick(); opcode = 5'b01000;
    #1 chk_out("sw_ex", 0, ov(0,0,0,0,0,0,1,0,0,0), 0);
    tick(); #1 chk_out("sw_mem", 0, ov(0,1,0,0,0,0,1,0,0,0), 0);
    tick(); #1 chk_out("sw_done", 0, V_IDLE, 0);
    tick(); insn_valid = 1'b0; opcode = 5'b11111;
    #1 chk_out("lw_ex", 0, ov(0,0,0,0,0,0,1,0,0,0), 0);
    tick(); #1 chk_out("lw_mem", 0, ov(0,0,0,0,0,0,1,0,0,0), 0);
    tick(); #1 chk_out("lw_wb", 0, ov(0,0,1,1,0,0,0,0,0,0), 0);
    tick(); #1 chk_out("lw_idle", 0, V_IDLE, 0);

    // div: md_ready with exception in the 10th wait cycle.
    issue(5'b00000, 5'b00111);
    #1 chk_out("div_ex", 0, ov(0,0,0,0,0,0,0,0,1,0), 0); chk_out("div_ex", 1, ov(0,0,0,0,0,0,0,0,1,0), 0);
    for (int i = 1; i <= 10; i++) begin
      tick(); md_ready = (i == 10); md_exception = (i == 10);
      #1 chk_out("div_wait", 0, V_ZERO, 0);
    end
    tick(); md_ready = 1'b0; md_exception = 1'b0;
    #1 chk_out("div_wb", 0, ov(0,0,1,3,1,0,0,0,0,0), 5);
    tick(); #1 chk_out("div_idle", 0, V_IDLE, 0); chk_out("div_idle", 1, V_IDLE, 0);

    // mul: md_ready without exception in the 5th wait cycle.
    issue(5'b00000, 5'b00110);
    #1 chk_out("mul_ex", 0, ov(0,0,0,0,0,0,0,1,0,0), 0);
    for (int i = 1; i <= 5; i++) begin
      tick(); md_ready = (i == 5); md_exception = 1'b0;
      #1 chk_out("mul_wait", 0, V_ZERO, 0);
    end
    tick(); md_ready = 1'b0;
    #1 chk_out("mul_wb", 0, ov(0,0,1,2,0,0,0,0,0,0), 0); chk_out("mul_wb", 1, ov(0,0,1,2,0,0,0,0,0,0), 0);
    tick(); #1 chk_out("mul_idle", 0, V_IDLE, 0);

    // mul timeout on the MD_TIMEOUT=8 instance; md_ready later only finishes the other one.
    issue(5'b00000, 5'b00110);
    #1 chk_out("to_ex", 1, ov(0,0,0,0,0,0,0,1,0,0), 0);
    for (int i = 1; i <= 8; i++) begin
      tick(); #1 chk_out("to_wait", 1, V_ZERO, 0);
    end
    tick(); #1 chk_out("to_wb", 1, ov(0,0,1,3,1,0,0,0,0,0), 4); chk_out("to_other_wait", 0, V_ZERO, 0);
    tick(); md_ready = 1'b1; md_exception = 1'b1;
    #1 chk_out("to_idle_mdrdy", 1, V_IDLE, 0);
    tick(); md_ready = 1'b0; md_exception = 1'b0;
    #1 chk_out("to_other_wb", 0, ov(0,0,1,3,1,0,0,0,0,0), 4); chk_out("to_idle2", 1, V_IDLE, 0);
    tick(); #1 chk_out("to_done", 0, V_IDLE, 0);

    // md_ready arriving in the timeout cycle wins.
    issue(5'b00000, 5'b00110);
    for (int i = 1; i <= 8; i++) begin
      tick(); md_ready = (i == 8); md_exception = 1'b0;
    end
    tick(); md_ready = 1'b0;
    #1 chk_out("race_wb", 1, ov(0,0,1,2,0,0,0,0,0,0), 0); chk_out("race_wb", 0, ov(0,0,1,2,0,0,0,0,0,0), 0);
    tick(); #1 chk_out("race_idle", 1, V_IDLE, 0);

    // Illegal encodings: bad opcode and bad R-type func.
    issue(5'b11111, 5'b00000);
    #1 chk_out("ill_op", 0, ov(0,0,0,0,0,0,0,0,0,1), 0); chk_out("ill_op", 1, ov(0,0,0,0,0,0,0,0,0,1), 0);
    tick(); #1 chk_out("ill_idle", 0, V_IDLE, 0);
    issue(5'b00000, 5'b01000);
    #1 chk_out("ill_fn", 0, ov(0,0,0,0,0,0,0,0,0,1), 0);
    tick();

    // Reset in the middle of a div wait aborts it.
    issue(5'b00000, 5'b00111);
    tick(); tick(); tick();
    reset = 1'b0;
    #1 chk_out("rst_md", 0, V_ZERO, 0); chk_out("rst_md", 1, V_ZERO, 0);
    tick(); reset = 1'b1; md_ready = 1'b1; md_exception = 1'b0;
    #1 chk_out("rst_idle", 0, V_IDLE, 0); chk_out("rst_idle", 1, V_IDLE, 0);
    for (int i = 1; i <= 4; i++) begin
      tick(); #1 chk_out("rst_no_wb", 0, V_IDLE, 0);
    end
    md_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
